// File: rtl/instr_fetch_unit.sv
// Program-counter owner for the 128x8 synchronous program ROM: fetches 1- or 2-byte
// instructions, hands them to the control unit over valid/ready, and takes branch redirects.
module instr_fetch_unit #(
  parameter int          ROM_DEPTH = 128,
  parameter logic [7:0]  RESET_PC  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic [7:0] instr_pc,
  output logic       instr_len2,
  output logic       illegal_op,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic       fetch_fault
);

  typedef enum logic [2:0] {
    S_ISSUE,
    S_CAP_OP,
    S_CAP_OPR,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [8:0] DEPTH = 9'(ROM_DEPTH);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic       len2_q, len2_d;
  logic       illegal_q, illegal_d;

  logic       dec_len2;
  logic       dec_legal;
  logic [8:0] pc_wide;
  logic [8:0] pc_plus1_wide;
  logic [7:0] pc_step;

  // Length/legality decode of the opcode byte currently on the ROM bus.
  always_comb begin
    dec_len2  = 1'b0;
    dec_legal = 1'b0;
    case (rom_data) inside
      8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, [8'h20:8'h28]: begin
        dec_len2  = 1'b1;
        dec_legal = 1'b1;
      end
      [8'h42:8'h4D]: dec_legal = 1'b1;
      default: begin
        dec_len2  = 1'b0;
        dec_legal = 1'b0;
      end
    endcase
  end

  assign pc_wide       = {1'b0, pc_q};
  assign pc_plus1_wide = {1'b0, pc_q} + 9'd1;
  assign pc_step       = len2_q ? 8'd2 : 8'd1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    len2_d     = len2_q;
    illegal_d  = illegal_q;

    case (state_q)
      S_ISSUE: begin
        if (pc_wide >= DEPTH) state_d = S_FAULT;
        else                  state_d = S_CAP_OP;
      end
      S_CAP_OP: begin
        opcode_d   = rom_data;
        instr_pc_d = pc_q;
        len2_d     = dec_len2;
        illegal_d  = ~dec_legal;
        if (dec_len2) begin
          if (pc_plus1_wide >= DEPTH) state_d = S_FAULT;
          else                        state_d = S_CAP_OPR;
        end else begin
          operand_d = 8'h00;
          state_d   = S_HOLD;
        end
      end
      S_CAP_OPR: begin
        operand_d = rom_data;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + pc_step;
          state_d = S_ISSUE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // A redirect overrides whatever the fetch sequence wanted, including a handshake.
    if (branch_taken && (state_q != S_FAULT)) begin
      pc_d    = branch_target;
      state_d = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ISSUE;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      instr_pc_q <= RESET_PC;
      len2_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
      len2_q     <= len2_d;
      illegal_q  <= illegal_d;
    end
  end

  // CAP_OP reads ahead one byte so the operand is on the bus by CAP_OPR.
  assign rom_addr    = (state_q == S_CAP_OP) ? (pc_q + 8'd1) : pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign fetch_fault = (state_q == S_FAULT);
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_pc    = instr_pc_q;
  assign instr_len2  = len2_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural 1-cycle-latency ROM, a table of
// expected instructions for straight-line fetch, and hand sequences for the corner cases.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instr_pc;
  logic       instr_len2;
  logic       illegal_op;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       fetch_fault;

  logic [7:0] rom [256];

  int checks;
  int fails;

  typedef struct {
    logic [7:0] opcode;
    logic [7:0] operand;
    logic [7:0] pc;
    logic       len2;
    logic       illegal;
    int         gap;
  } vec_t;

  vec_t vecs [4];

  instr_fetch_unit #(.ROM_DEPTH(128), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .instr_pc      (instr_pc),
    .instr_len2    (instr_len2),
    .illegal_op    (illegal_op),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data shows the byte addressed at the previous rising edge.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic br, input logic [7:0] target);
    instr_ready   = ready;
    branch_taken  = br;
    branch_target = target;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadRom(input logic [7:0] bytes[$], input logic [7:0] base);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < bytes.size(); i++) rom[8'(base + 8'(i))] = bytes[i];
  endtask

  // Leaves the DUT in ISSUE at RESET_PC with reset released.
  task automatic applyReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic waitValid(output int cycles, input int budget);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!instr_valid && cycles < budget);
    if (!instr_valid) begin
      checks++;
      fails++;
      $display("[TB] FAIL wait_valid: valid=0 after %0d cycles, expected 1", cycles);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"},    32'(instr_valid), 32'h0);
    checkOutput({tag, "_opcode"},   32'(opcode),      32'h0);
    checkOutput({tag, "_operand"},  32'(operand),     32'h0);
    checkOutput({tag, "_instr_pc"}, 32'(instr_pc),    32'h0);
    checkOutput({tag, "_len2"},     32'(instr_len2),  32'h0);
    checkOutput({tag, "_illegal"},  32'(illegal_op),  32'h0);
    checkOutput({tag, "_fault"},    32'(fetch_fault), 32'h0);
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr),    32'h0);
  endtask

  initial begin
    int cyc;
    logic [7:0] prog1[$];

    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    prog1 = '{8'h86, 8'h00, 8'h88, 8'h01, 8'h42, 8'h96, 8'hE0};

    // Gap = rising edges from the previous reference point (reset release or previous
    // valid cycle) to this instruction's valid cycle.
    vecs[0] = '{opcode: 8'h86, operand: 8'h00, pc: 8'h00, len2: 1'b1, illegal: 1'b0, gap: 3};
    vecs[1] = '{opcode: 8'h88, operand: 8'h01, pc: 8'h02, len2: 1'b1, illegal: 1'b0, gap: 4};
    vecs[2] = '{opcode: 8'h42, operand: 8'h00, pc: 8'h04, len2: 1'b0, illegal: 1'b0, gap: 3};
    vecs[3] = '{opcode: 8'h96, operand: 8'hE0, pc: 8'h05, len2: 1'b1, illegal: 1'b0, gap: 4};

    // Reset state
    loadRom(prog1, 8'h00);
    reset = 1'b1;
    step();
    step();
    checkResetOutputs("reset");
    reset = 1'b0;

    // Straight-line fetch with ready held high
    for (int i = 0; i < 4; i++) begin
      waitValid(cyc, 10);
      checkOutput($sformatf("seq%0d_gap", i),     32'(cyc),        32'(vecs[i].gap));
      checkOutput($sformatf("seq%0d_opcode", i),  32'(opcode),     32'(vecs[i].opcode));
      checkOutput($sformatf("seq%0d_operand", i), 32'(operand),    32'(vecs[i].operand));
      checkOutput($sformatf("seq%0d_pc", i),      32'(instr_pc),   32'(vecs[i].pc));
      checkOutput($sformatf("seq%0d_len2", i),    32'(instr_len2), 32'(vecs[i].len2));
      checkOutput($sformatf("seq%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].illegal));
    end
    step();
    checkOutput("seq_valid_drop", 32'(instr_valid), 32'h0);

    // Backpressure: the held instruction must not move while ready is low
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyReset();
    waitValid(cyc, 10);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("hold%0d_valid", i),   32'(instr_valid), 32'h1);
      checkOutput($sformatf("hold%0d_opcode", i),  32'(opcode),      32'h86);
      checkOutput($sformatf("hold%0d_operand", i), 32'(operand),     32'h00);
      checkOutput($sformatf("hold%0d_pc", i),      32'(instr_pc),    32'h00);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    step();
    checkOutput("hold_release_valid", 32'(instr_valid), 32'h0);
    checkOutput("hold_release_addr",  32'(rom_addr),    32'h02);

    // Redirect while the operand of the instruction at pc=2 is being captured
    applyReset();
    waitValid(cyc, 10);
    step();
    step();
    step();
    checkOutput("br_opr_addr", 32'(rom_addr), 32'h02);
    applyStimulus(1'b1, 1'b1, 8'h04);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("br_opr_valid", 32'(instr_valid), 32'h0);
    checkOutput("br_opr_addr2", 32'(rom_addr),    32'h04);
    waitValid(cyc, 10);
    checkOutput("br_opr_gap",    32'(cyc),      32'd2);
    checkOutput("br_opr_pc",     32'(instr_pc), 32'h04);
    checkOutput("br_opr_opcode", 32'(opcode),   32'h42);

    // Redirect in the same cycle as the HOLD handshake wins over pc+len
    applyReset();
    waitValid(cyc, 10);
    applyStimulus(1'b1, 1'b1, 8'h04);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("br_hold_valid", 32'(instr_valid), 32'h0);
    checkOutput("br_hold_addr",  32'(rom_addr),    32'h04);
    waitValid(cyc, 10);
    checkOutput("br_hold_pc", 32'(instr_pc), 32'h04);

    // 2-byte opcode in the last ROM slot: operand fetch faults
    loadRom('{8'h86}, 8'h7F);
    applyReset();
    applyStimulus(1'b1, 1'b1, 8'h7F);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("flt_issue_addr", 32'(rom_addr), 32'h7F);
    step();
    checkOutput("flt_capop_addr", 32'(rom_addr),    32'h80);
    checkOutput("flt_pre_fault",  32'(fetch_fault), 32'h0);
    step();
    checkOutput("flt_fault", 32'(fetch_fault), 32'h1);
    checkOutput("flt_valid", 32'(instr_valid), 32'h0);
    checkOutput("flt_addr",  32'(rom_addr),    32'h7F);
    applyStimulus(1'b1, 1'b1, 8'h00);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00);
    step();
    checkOutput("flt_br_ignored_fault", 32'(fetch_fault), 32'h1);
    checkOutput("flt_br_ignored_addr",  32'(rom_addr),    32'h7F);
    reset = 1'b1;
    step();
    checkResetOutputs("flt_reset");
    reset = 1'b0;

    // Sequential advance past the last ROM address faults instead of wrapping
    loadRom('{8'h42, 8'h43}, 8'h7E);
    applyReset();
    applyStimulus(1'b1, 1'b1, 8'h7E);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitValid(cyc, 10);
    checkOutput("end_pc0", 32'(instr_pc), 32'h7E);
    waitValid(cyc, 10);
    checkOutput("end_pc1",     32'(instr_pc), 32'h7F);
    checkOutput("end_opcode1", 32'(opcode),   32'h43);
    step();
    checkOutput("end_addr", 32'(rom_addr), 32'h80);
    step();
    checkOutput("end_fault", 32'(fetch_fault), 32'h1);
    checkOutput("end_valid", 32'(instr_valid), 32'h0);

    // Illegal opcode is delivered as a 1-byte instruction
    loadRom('{8'hFF, 8'h42}, 8'h00);
    applyReset();
    waitValid(cyc, 10);
    checkOutput("ill_gap",     32'(cyc),        32'd2);
    checkOutput("ill_opcode",  32'(opcode),     32'hFF);
    checkOutput("ill_flag",    32'(illegal_op), 32'h1);
    checkOutput("ill_len2",    32'(instr_len2), 32'h0);
    checkOutput("ill_operand", 32'(operand),    32'h00);
    waitValid(cyc, 10);
    checkOutput("ill_next_pc",   32'(instr_pc),   32'h01);
    checkOutput("ill_next_flag", 32'(illegal_op), 32'h0);

    // Reset in the middle of CAP_OP for the instruction at pc=2
    loadRom(prog1, 8'h00);
    applyReset();
    waitValid(cyc, 10);
    step();
    step();
    checkOutput("mid_capop_addr", 32'(rom_addr), 32'h03);
    reset = 1'b1;
    step();
    checkResetOutputs("mid_reset");
    reset = 1'b0;
    waitValid(cyc, 10);
    checkOutput("mid_refetch_gap",    32'(cyc),     32'd3);
    checkOutput("mid_refetch_pc",     32'(instr_pc), 32'h00);
    checkOutput("mid_refetch_opcode", 32'(opcode),   32'h86);
    checkOutput("mid_refetch_oper",   32'(operand),  32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
